reg_bank8_wport: RTL and testbench
==================================

// Module: reg_bank8_wport
// PURPOSE
//  8-entry x WIDTH register bank; direct downstream consumer of the 3-to-8 write-address decoder.
//  Takes the decoder's one-hot select (Y0..Y7 -> WSEL[0..7]) plus write data and performs the
//  clocked write. Provides two registered read ports (A, B) with same-cycle write bypass.
//  Flags malformed selects, since a one-hot fault would otherwise silently corrupt state.
// PARAMETERS
//  WIDTH     8  data width of each register, WDATA, QA and QB
//  ZERO_REG  0  1: register 0 is hardwired to zero (writes to it ignored, reads return 0)
// PORTS
//  CLK      in   1      rising-edge clock; sole clock of the block
//  RST      in   1      synchronous reset, active-high
//  WEN      in   1      write request this cycle
//  WSEL     in   8      one-hot write select; bit i = decoder output Yi
//  WDATA    in   WIDTH  write data
//  RA       in   3      read address, port A
//  RB       in   3      read address, port B
//  QA       out  WIDTH  registered read data, port A
//  QB       out  WIDTH  registered read data, port B
//  WR_ACK   out  1      one-cycle pulse: a write was accepted on the previous edge
//  SEL_ERR  out  1      sticky: WEN seen with a non-one-hot WSEL
// BEHAVIOUR
//  - Reset: RST=1 at a CLK edge clears all 8 registers, QA, QB, WR_ACK and SEL_ERR to 0.
//    RST has priority over every other input. A write presented in the reset cycle is discarded.
//  - Accepted write: WEN=1 and WSEL has exactly one bit set (index i).
//    reg[i] <= WDATA on that edge, and WR_ACK=1 for the following cycle only.
//  - ZERO_REG=1 and i=0: the write is still accepted (WR_ACK pulses), but reg[0] stays 0.
//  - WEN=1 with WSEL=8'h00 or >=2 bits set: no register changes, WR_ACK stays 0,
//    SEL_ERR <= 1. SEL_ERR then holds until RST.
//  - WEN=0: WSEL and WDATA are ignored entirely, including for error checking.
//  - Read latency is 1 cycle: at each edge QA <= value(RA) and QB <= value(RB).
//    value(r) = WDATA if an accepted write to r happens on the same edge (bypass);
//    otherwise value(r) = reg[r]. With ZERO_REG=1, value(0) is always 0 (no bypass).
//  - RA = RB is legal: both ports return identical data.
//  - Back-to-back writes to the same index: the last write wins.
//    WR_ACK stays high across consecutive accepted writes.
//  - No internal state beyond regs/QA/QB/WR_ACK/SEL_ERR; no X may reach outputs after first RST.
// TESTING
//  1 Reset: drive RST=1 for 1 edge with WEN=1, WSEL=8'h01, WDATA=8'hAA.
//    -> all regs, QA, QB = 0; WR_ACK = SEL_ERR = 0.
//  2 Write/read: write 8'h3C via WSEL=8'h08, then RA=3 next cycle.
//    -> WR_ACK=1 for exactly 1 cycle; QA=8'h3C one cycle after RA applied.
//  3 Bypass: WEN=1, WSEL=8'h20, WDATA=8'h5A, RA=5, RB=5 on the same edge.
//    -> QA = QB = 8'h5A right after that edge.
//  4 Bad select: WEN=1, WSEL=8'h00, then WSEL=8'h81, then a valid write.
//    -> no register changes for the bad selects; SEL_ERR=1 from the first bad edge until RST.
//  5 ZERO_REG=1: write 8'hFF with WSEL=8'h01, RA=0 on the same edge.
//    -> QA=0, WR_ACK pulses; with ZERO_REG=0, QA=8'hFF.
//  6 WEN=0 with WSEL=8'hFF -> no writes, SEL_ERR stays 0; reset mid-run clears a set SEL_ERR.

Source files
------------

// File: rtl/reg_bank8_wport.sv
// 8 x WIDTH register bank fed by a one-hot write select from a 3-to-8 decoder.
// Two registered read ports with same-edge write bypass; malformed selects latch a sticky error.

module reg_bank8_cell #(
  parameter int WIDTH     = 8,
  parameter bit HARD_ZERO = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // A hardwired-zero cell is simply held in reset; synthesis folds it to a constant.
  always_ff @(posedge CLK) begin
    if (RST || HARD_ZERO) q <= '0;
    else if (we)          q <= d;
  end

endmodule

module reg_bank8_wport #(
  parameter int WIDTH    = 8,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WEN,
  input  logic [7:0]       WSEL,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [2:0]       RA,
  input  logic [2:0]       RB,
  output logic [WIDTH-1:0] QA,
  output logic [WIDTH-1:0] QB,
  output logic             WR_ACK,
  output logic             SEL_ERR
);

  localparam int NUM_REGS = 8;

  typedef struct packed {
    logic             en;
    logic [7:0]       sel;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t                           req;
  logic                              sel_onehot;
  logic                              wr_accept;
  logic                              sel_bad;
  logic [NUM_REGS-1:0]               wr_hit;
  logic [NUM_REGS-1:0][WIDTH-1:0]    rf;
  logic [WIDTH-1:0]                  val_a;
  logic [WIDTH-1:0]                  val_b;

  assign req = '{en: WEN, sel: WSEL, data: WDATA};

  // x & (x-1) clears the lowest set bit, so zero means at most one bit was set.
  assign sel_onehot = (req.sel != 8'h00) && ((req.sel & (req.sel - 8'd1)) == 8'h00);
  assign wr_accept  = req.en && sel_onehot;
  assign sel_bad    = req.en && !sel_onehot;
  assign wr_hit     = wr_accept ? req.sel : 8'h00;

  generate
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
      reg_bank8_cell #(
        .WIDTH     (WIDTH),
        .HARD_ZERO (ZERO_REG && (i == 0))
      ) u_cell (
        .CLK (CLK),
        .RST (RST),
        .we  (wr_hit[i]),
        .d   (req.data),
        .q   (rf[i])
      );
    end
  endgenerate

  function automatic logic [WIDTH-1:0] rd_val(
    input logic [2:0]                    addr,
    input logic [NUM_REGS-1:0]           hit,
    input logic [WIDTH-1:0]              wdata,
    input logic [NUM_REGS-1:0][WIDTH-1:0] regs
  );
    // Register 0 never bypasses when hardwired: a write to it must read back as zero.
    if (ZERO_REG && addr == 3'd0) return '0;
    if (hit[addr])                return wdata;
    return regs[addr];
  endfunction

  always_comb begin
    val_a = rd_val(RA, wr_hit, req.data, rf);
    val_b = rd_val(RB, wr_hit, req.data, rf);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      QA      <= '0;
      QB      <= '0;
      WR_ACK  <= 1'b0;
      SEL_ERR <= 1'b0;
    end else begin
      QA     <= val_a;
      QB     <= val_b;
      WR_ACK <= wr_accept;
      if (sel_bad) SEL_ERR <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_bank8_wport.sv
// Directed bench: two banks (ZERO_REG=0 and ZERO_REG=1) share stimulus; outputs checked per step.

module tb_reg_bank8_wport;

  logic       CLK = 1'b0;
  logic       RST;
  logic       WEN;
  logic [7:0] WSEL;
  logic [7:0] WDATA;
  logic [2:0] RA;
  logic [2:0] RB;

  logic [7:0] qa0, qb0, qa1, qb1;
  logic       ack0, err0, ack1, err1;

  int vectors = 0;
  int errors  = 0;

  always #5 CLK = ~CLK;

  reg_bank8_wport #(.WIDTH(8), .ZERO_REG(1'b0)) dut0 (
    .CLK (CLK), .RST (RST), .WEN (WEN), .WSEL (WSEL), .WDATA (WDATA),
    .RA (RA), .RB (RB), .QA (qa0), .QB (qb0), .WR_ACK (ack0), .SEL_ERR (err0)
  );

  reg_bank8_wport #(.WIDTH(8), .ZERO_REG(1'b1)) dut1 (
    .CLK (CLK), .RST (RST), .WEN (WEN), .WSEL (WSEL), .WDATA (WDATA),
    .RA (RA), .RB (RB), .QA (qa1), .QB (qb1), .WR_ACK (ack1), .SEL_ERR (err1)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset with a write pending: the write must be discarded.
    RST = 1'b1; WEN = 1'b1; WSEL = 8'h01; WDATA = 8'hAA; RA = 3'd0; RB = 3'd0;
    step();
    chk("rst_qa0", qa0, 8'h00);   chk("rst_qb0", qb0, 8'h00);
    chk("rst_ack0", {7'd0, ack0}, 8'h00); chk("rst_err0", {7'd0, err0}, 8'h00);
    chk("rst_qa1", qa1, 8'h00);   chk("rst_ack1", {7'd0, ack1}, 8'h00);

    RST = 1'b0; WEN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      RA = 3'(i); RB = 3'(7 - i);
      step();
      chk($sformatf("rst_reg_a%0d", i), qa0, 8'h00);
      chk($sformatf("rst_reg_b%0d", 7 - i), qb0, 8'h00);
    end

    // Plain write then read.
    WEN = 1'b1; WSEL = 8'h08; WDATA = 8'h3C; RA = 3'd0; RB = 3'd1;
    step();
    chk("wr_ack_hi", {7'd0, ack0}, 8'h01);
    WEN = 1'b0; RA = 3'd3;
    step();
    chk("wr_ack_lo", {7'd0, ack0}, 8'h00);
    chk("rd_r3_a0", qa0, 8'h3C);
    chk("rd_r3_a1", qa1, 8'h3C);

    // Same-edge bypass on both ports.
    WEN = 1'b1; WSEL = 8'h20; WDATA = 8'h5A; RA = 3'd5; RB = 3'd5;
    step();
    chk("byp_qa0", qa0, 8'h5A); chk("byp_qb0", qb0, 8'h5A);
    chk("byp_qb1", qb1, 8'h5A); chk("byp_ack", {7'd0, ack0}, 8'h01);

    // Back-to-back writes to the same index; ack stays high, last wins.
    WSEL = 8'h20; WDATA = 8'h11; RA = 3'd3; RB = 3'd2;
    step();
    chk("b2b_ack1", {7'd0, ack0}, 8'h01);
    WDATA = 8'h22;
    step();
    chk("b2b_ack2", {7'd0, ack0}, 8'h01);
    WEN = 1'b0; RA = 3'd5;
    step();
    chk("b2b_last", qa0, 8'h22);
    chk("b2b_ack_lo", {7'd0, ack0}, 8'h00);

    // WEN=0 ignores a garbage select entirely.
    WEN = 1'b0; WSEL = 8'hFF; WDATA = 8'hEE; RA = 3'd1; RB = 3'd3;
    step();
    step();
    chk("noen_err", {7'd0, err0}, 8'h00);
    chk("noen_ack", {7'd0, ack0}, 8'h00);
    chk("noen_r1", qa0, 8'h00);
    chk("noen_r3", qb0, 8'h3C);

    // Bad selects: zero, then two bits set.
    WEN = 1'b1; WSEL = 8'h00; WDATA = 8'h99; RA = 3'd0; RB = 3'd7;
    step();
    chk("bad0_err", {7'd0, err0}, 8'h01);
    chk("bad0_err1", {7'd0, err1}, 8'h01);
    chk("bad0_ack", {7'd0, ack0}, 8'h00);
    WSEL = 8'h81;
    step();
    chk("bad81_err", {7'd0, err0}, 8'h01);
    chk("bad81_ack", {7'd0, ack0}, 8'h00);
    chk("bad81_qa", qa0, 8'h00);
    chk("bad81_qb", qb0, 8'h00);
    WEN = 1'b0;
    step();
    chk("bad_r0", qa0, 8'h00);
    chk("bad_r7", qb0, 8'h00);
    WEN = 1'b1; WSEL = 8'h02; WDATA = 8'h47; RA = 3'd3; RB = 3'd5;
    step();
    chk("good_ack", {7'd0, ack0}, 8'h01);
    chk("good_err", {7'd0, err0}, 8'h01);
    WEN = 1'b0; RA = 3'd1;
    step();
    chk("good_r1", qa0, 8'h47);
    chk("good_r5", qb0, 8'h22);
    chk("err_hold", {7'd0, err0}, 8'h01);

    // Register 0: real in dut0, hardwired zero in dut1 (no bypass).
    WEN = 1'b1; WSEL = 8'h01; WDATA = 8'hFF; RA = 3'd0; RB = 3'd0;
    step();
    chk("z_byp_qa0", qa0, 8'hFF);
    chk("z_byp_qa1", qa1, 8'h00);
    chk("z_byp_qb1", qb1, 8'h00);
    chk("z_ack1", {7'd0, ack1}, 8'h01);
    WEN = 1'b0;
    step();
    chk("z_rd_qa0", qa0, 8'hFF);
    chk("z_rd_qa1", qa1, 8'h00);
    chk("z_ack_lo", {7'd0, ack1}, 8'h00);

    // Mid-run reset clears the sticky error and the registers.
    RST = 1'b1;
    step();
    chk("rst2_err0", {7'd0, err0}, 8'h00);
    chk("rst2_err1", {7'd0, err1}, 8'h00);
    chk("rst2_qa0", qa0, 8'h00);
    RST = 1'b0; RA = 3'd3; RB = 3'd1;
    step();
    chk("rst2_r3", qa0, 8'h00);
    chk("rst2_r1", qb0, 8'h00);
    RA = 3'd0;
    step();
    chk("rst2_r0", qa0, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
